sump_cmd_decoder: RTL and testbench

- Sits directly downstream of the Tiny-UART receiver.
- Consumes its 40-bit command word and strobe, and decodes SUMP short commands (1 byte) and long commands (opcode + 32-bit payload).
- Holds the resulting configuration registers for the capture core and issues control pulses.
- Sequences multi-byte replies (ID, optionally metadata) to the UART transmitter over a valid/ready byte handshake.

---
 rtl/sump_cmd_decoder_pkg.sv | 49 ++++
 rtl/sump_cmd_decoder_if.sv | 9 +
 rtl/sump_cmd_decoder_reply_seq.sv | 70 +++++++
 rtl/sump_cmd_decoder.sv | 110 +++++++++++
 tb/tb_sump_cmd_decoder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sump_cmd_decoder_pkg.sv
// Opcodes, reply FSM states and reply ROM contents for the SUMP command decoder.
// SUMP_METADATA_EN adds the metadata reply ROM.
package logip_cmd_pkg;

    localparam logic [7:0] OP_RESET = 8'h00;
    localparam logic [7:0] OP_RUN   = 8'h01;
    localparam logic [7:0] OP_ID    = 8'h02;
    localparam logic [7:0] OP_META  = 8'h04;
    localparam logic [7:0] OP_XON   = 8'h11;
    localparam logic [7:0] OP_XOFF  = 8'h13;
    localparam logic [7:0] OP_DIV   = 8'h80;
    localparam logic [7:0] OP_CNT   = 8'h81;
    localparam logic [7:0] OP_FLAGS = 8'h82;

    typedef enum logic {IDLE, REPLY} reply_state_e;

    localparam int         ID_LEN  = 4;
    localparam logic [3:0] ID_LAST = 4'(ID_LEN - 1);

    function automatic logic [7:0] id_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h31;
            2'd1:    return 8'h41;
            2'd2:    return 8'h4C;
            default: return 8'h53;
        endcase
    endfunction

`ifdef SUMP_METADATA_EN
    localparam int         META_LEN  = 13;
    localparam logic [3:0] META_LAST = 4'(META_LEN - 1);

    // Device name "logIP", then 32 probes, then end-of-metadata
    function automatic logic [7:0] meta_byte(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h6C;
            4'd2:    return 8'h6F;
            4'd3:    return 8'h67;
            4'd4:    return 8'h49;
            4'd5:    return 8'h50;
            4'd7:    return 8'h20;
            4'd11:   return 8'h20;
            default: return 8'h00;
        endcase
    endfunction
`endif

endpackage

// File: rtl/sump_cmd_decoder_if.sv
// Reply byte stream to the UART transmitter (valid/ready).
interface sump_cmd_decoder_if;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;

    modport master (output tx_data_o, output tx_valid_o, input tx_ready_i);
    modport slave  (input tx_data_o, input tx_valid_o, output tx_ready_i);
endinterface

// File: rtl/sump_cmd_decoder_reply_seq.sv
// Reply sequencer: walks the ID (or, with SUMP_METADATA_EN, metadata) ROM
// over the transmitter handshake. Starts are ignored while a reply is running.
module sump_reply_seq
    import logip_cmd_pkg::*;
(
    input  logic clk_i,
    input  logic rst_in,
    input  logic start_i,
`ifdef SUMP_METADATA_EN
    input  logic meta_i,
`endif
    sump_cmd_decoder_if.master tx,
    output logic busy_o
);

    reply_state_e state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic         last;
    logic [7:0]   rom_byte;

`ifdef SUMP_METADATA_EN
    logic sel_q;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in)                          sel_q <= 1'b0;
        else if (state_q == IDLE && start_i)  sel_q <= meta_i;
    end

    assign last     = idx_q == (sel_q ? META_LAST : ID_LAST);
    assign rom_byte = sel_q ? meta_byte(idx_q) : id_byte(idx_q[1:0]);
`else
    assign last     = idx_q == ID_LAST;
    assign rom_byte = id_byte(idx_q[1:0]);
`endif

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = REPLY;
                idx_d   = '0;
            end
            REPLY: if (tx.tx_ready_i) begin
                if (last) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o        = state_q == REPLY;
    assign tx.tx_valid_o = busy_o;
    assign tx.tx_data_o  = busy_o ? rom_byte : 8'h00;

endmodule

// File: rtl/sump_cmd_decoder.sv
// SUMP command decoder: registers capture configuration, issues control pulses
// and launches replies. SUMP_METADATA_EN enables the 0x04 metadata reply.
module sump_cmd_decoder
    import logip_cmd_pkg::*;
#(
    parameter int TRIG_STAGES = 4,
    parameter int CMD_WIDTH   = 40
) (
    input  logic                      clk_i,
    input  logic                      rst_in,
    input  logic [CMD_WIDTH-1:0]      cmd_i,
    input  logic                      stb_i,
    sump_cmd_decoder_if.master        tx,
    output logic                      sw_rst_o,
    output logic                      arm_o,
    output logic                      xoff_o,
    output logic [23:0]               div_o,
    output logic [15:0]               read_cnt_o,
    output logic [15:0]               delay_cnt_o,
    output logic [31:0]               flags_o,
    output logic [TRIG_STAGES*32-1:0] trig_mask_o,
    output logic [TRIG_STAGES*32-1:0] trig_val_o,
    output logic [TRIG_STAGES*32-1:0] trig_cfg_o
);

    logic        is_long, short_stb, long_stb, busy, reply_start;
    logic [7:0]  short_op, long_op;
    logic [31:0] payload;

    // Long opcodes all have bit 7 set, so the opcode byte decides the format;
    // this keeps long commands whose payload has bit 31 clear decoding as long.
    assign is_long   = cmd_i[7];
    assign short_op  = cmd_i[39:32];
    assign long_op   = cmd_i[7:0];
    assign payload   = cmd_i[39:8];
    assign short_stb = stb_i && !is_long;
    assign long_stb  = stb_i && is_long;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            sw_rst_o    <= 1'b0;
            arm_o       <= 1'b0;
            xoff_o      <= 1'b0;
            div_o       <= '0;
            read_cnt_o  <= '0;
            delay_cnt_o <= '0;
            flags_o     <= '0;
            trig_mask_o <= '0;
            trig_val_o  <= '0;
            trig_cfg_o  <= '0;
        end else begin
            sw_rst_o <= 1'b0;
            arm_o    <= 1'b0;
            if (short_stb) begin
                case (short_op)
                    OP_RESET: begin
                        sw_rst_o <= 1'b1;
                        xoff_o   <= 1'b0;
                    end
                    OP_RUN:  arm_o  <= 1'b1;
                    OP_XON:  xoff_o <= 1'b0;
                    OP_XOFF: xoff_o <= 1'b1;
                    default: ;
                endcase
            end
            if (long_stb) begin
                case (long_op)
                    OP_DIV:   div_o <= payload[23:0];
                    OP_CNT: begin
                        read_cnt_o  <= payload[15:0];
                        delay_cnt_o <= payload[31:16];
                    end
                    OP_FLAGS: flags_o <= payload;
                    default: ;
                endcase
                // 0xC0+4n: stage n mask/value/config; stages beyond TRIG_STAGES never match
                for (int s = 0; s < TRIG_STAGES; s++) begin
                    if (long_op[7:4] == 4'hC && int'(long_op[3:2]) == s) begin
                        case (long_op[1:0])
                            2'd0:    trig_mask_o[32*s +: 32] <= payload;
                            2'd1:    trig_val_o[32*s +: 32]  <= payload;
                            2'd2:    trig_cfg_o[32*s +: 32]  <= payload;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

`ifdef SUMP_METADATA_EN
    logic is_meta;
    assign is_meta     = short_stb && short_op == OP_META;
    assign reply_start = !busy && ((short_stb && short_op == OP_ID) || is_meta);
`else
    assign reply_start = !busy && short_stb && short_op == OP_ID;
`endif

    sump_reply_seq u_reply (
        .clk_i   (clk_i),
        .rst_in  (rst_in),
        .start_i (reply_start),
`ifdef SUMP_METADATA_EN
        .meta_i  (is_meta),
`endif
        .tx      (tx),
        .busy_o  (busy)
    );

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Scoreboard bench for sump_cmd_decoder: expected register snapshots and
// reply bytes are queued by the stimulus and checked by a negedge monitor.
module tb_sump_cmd_decoder;

    typedef struct {
        logic         sw_rst;
        logic         arm;
        logic         xoff;
        logic [23:0]  div;
        logic [15:0]  rd;
        logic [15:0]  dly;
        logic [31:0]  flags;
        logic [127:0] mask;
        logic [127:0] val;
        logic [127:0] cfg;
    } cfg_t;

    logic          clk_i = 1'b0;
    logic          rst_in = 1'b0;
    logic [39:0]   cmd_i = '0;
    logic          stb_i = 1'b0;
    logic          sw_rst_o, arm_o, xoff_o;
    logic [23:0]   div_o;
    logic [15:0]   read_cnt_o, delay_cnt_o;
    logic [31:0]   flags_o;
    logic [127:0]  trig_mask_o, trig_val_o, trig_cfg_o;

    sump_cmd_decoder_if tx ();

    sump_cmd_decoder #(.TRIG_STAGES(4), .CMD_WIDTH(40)) dut (
        .clk_i       (clk_i),
        .rst_in      (rst_in),
        .cmd_i       (cmd_i),
        .stb_i       (stb_i),
        .tx          (tx),
        .sw_rst_o    (sw_rst_o),
        .arm_o       (arm_o),
        .xoff_o      (xoff_o),
        .div_o       (div_o),
        .read_cnt_o  (read_cnt_o),
        .delay_cnt_o (delay_cnt_o),
        .flags_o     (flags_o),
        .trig_mask_o (trig_mask_o),
        .trig_val_o  (trig_val_o),
        .trig_cfg_o  (trig_cfg_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    cfg_t        e;
    cfg_t        cfg_q[$];
    logic [7:0]  byte_q[$];
    logic        stb_seen = 1'b0;
    int          rdy_mode = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_cfg(input cfg_t x);
        chk("sw_rst", sw_rst_o, x.sw_rst);
        chk("arm", arm_o, x.arm);
        chk("xoff", xoff_o, x.xoff);
        chk("div", div_o, x.div);
        chk("read_cnt", read_cnt_o, x.rd);
        chk("delay_cnt", delay_cnt_o, x.dly);
        chk("flags", flags_o, x.flags);
        chk("trig_mask", trig_mask_o, x.mask);
        chk("trig_val", trig_val_o, x.val);
        chk("trig_cfg", trig_cfg_o, x.cfg);
    endtask

    always @(posedge clk_i) stb_seen <= stb_i;

    // Monitor: register snapshot one cycle after each strobe, reply bytes on handshake
    always @(negedge clk_i) begin
        if (rst_in) begin
            if (stb_seen) begin
                if (cfg_q.size() == 0) chk("cfg queue underflow", 1, 0);
                else cmp_cfg(cfg_q.pop_front());
            end else begin
                chk("sw_rst idle", sw_rst_o, 0);
                chk("arm idle", arm_o, 0);
            end
            if (prev_stall) begin
                chk("valid held while stalled", tx.tx_valid_o, 1);
                chk("data stable while stalled", tx.tx_data_o, prev_data);
            end
            if (tx.tx_valid_o && tx.tx_ready_i) begin
                if (byte_q.size() == 0) chk("unexpected reply byte", tx.tx_data_o, 8'hXX);
                else chk("reply byte", tx.tx_data_o, byte_q.pop_front());
            end
            prev_stall = tx.tx_valid_o && !tx.tx_ready_i;
            prev_data  = tx.tx_data_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Transmitter ready: 0 always ready, 1 one cycle in three, 2 never
    initial begin
        int ph = 0;
        tx.tx_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            ph = (ph + 1) % 3;
            case (rdy_mode)
                0:       tx.tx_ready_i = 1'b1;
                1:       tx.tx_ready_i = (ph == 0);
                default: tx.tx_ready_i = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [39:0] c);
        cfg_q.push_back(e);
        e.sw_rst = 1'b0;
        e.arm    = 1'b0;
        @(posedge clk_i);
        #1;
        cmd_i = c;
        stb_i = 1'b1;
        @(posedge clk_i);
        #1;
        stb_i = 1'b0;
        cmd_i = '0;
        repeat (2) @(posedge clk_i);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (byte_q.size() != 0 && n < 300) begin
            @(posedge clk_i);
            n++;
        end
        if (byte_q.size() != 0) chk({name, " drain timeout"}, byte_q.size(), 0);
        @(negedge clk_i);
        chk({name, " valid low after reply"}, tx.tx_valid_o, 0);
    endtask

    task automatic push_id();
        byte_q.push_back(8'h31);
        byte_q.push_back(8'h41);
        byte_q.push_back(8'h4C);
        byte_q.push_back(8'h53);
    endtask

    initial begin
        e = '{sw_rst: 0, arm: 0, xoff: 0, div: 0, rd: 0, dly: 0, flags: 0, mask: 0, val: 0, cfg: 0};
        #2;
        cmp_cfg(e);
        chk("reset valid", tx.tx_valid_o, 0);
        chk("reset data", tx.tx_data_o, 0);
        #20 rst_in = 1'b1;

        // ID reply, transmitter always ready
        push_id();
        send(40'h02_0000_0000);
        drain("id");

        // Long config commands
        e.div = 24'h123456;
        send(40'h00_1234_5680);
        e.rd = 16'h0080; e.dly = 16'h0040;
        send(40'h00_4000_8081);
        e.mask[63:32] = 32'hFFFF0000;
        send(40'hFF_FF00_00C4);
        e.val[63:32] = 32'h12345678;
        send(40'h12_3456_78C5);
        e.cfg[127:96] = 32'h800000AB;
        send(40'h80_0000_ABCE);
        e.flags = 32'hA5A50F0F;
        send(40'hA5_A50F_0F82);
        // Ignored: stage 4 mask, stage 0 slot 3, unknown long, unknown short
        send(40'hDE_ADBE_EFD0);
        send(40'hDE_ADBE_EFC3);
        send(40'hDE_ADBE_EF83);
        send(40'h7F_0000_0000);

        // XOFF then reset command, then arm
        e.xoff = 1'b1;
        send(40'h13_0000_0000);
        e.sw_rst = 1'b1; e.xoff = 1'b0;
        send(40'h00_0000_0000);
        e.arm = 1'b1;
        send(40'h01_0000_0000);

        // Stalled ID reply with a second request mid-reply
        rdy_mode = 1;
        push_id();
        send(40'h02_0000_0000);
        send(40'h02_0000_0000);
        drain("id stalled");
        rdy_mode = 0;
        repeat (3) @(posedge clk_i);

        // Metadata request
`ifdef SUMP_METADATA_EN
        foreach (byte_q[i]) byte_q.delete(i);
        begin
            logic [7:0] meta [13] = '{8'h01, 8'h6C, 8'h6F, 8'h67, 8'h49, 8'h50, 8'h00,
                                      8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00};
            foreach (meta[i]) byte_q.push_back(meta[i]);
        end
        send(40'h04_0000_0000);
        drain("meta");
`else
        send(40'h04_0000_0000);
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        chk("no metadata reply", tx.tx_valid_o, 0);
`endif

        // Asynchronous reset while a stalled reply is pending
        rdy_mode = 2;
        repeat (2) @(posedge clk_i);
        send(40'h02_0000_0000);
        @(negedge clk_i);
        chk("reply pending before reset", tx.tx_valid_o, 1);
        #2 rst_in = 1'b0;
        #1;
        chk("async reset valid", tx.tx_valid_o, 0);
        e = '{sw_rst: 0, arm: 0, xoff: 0, div: 0, rd: 0, dly: 0, flags: 0, mask: 0, val: 0, cfg: 0};
        cmp_cfg(e);
        byte_q.delete();
        cfg_q.delete();
        rdy_mode = 0;
        #13 rst_in = 1'b1;

        // Fresh reply after reset
        push_id();
        send(40'h02_0000_0000);
        drain("id after reset");

        if (cfg_q.size() != 0) chk("cfg queue leftover", cfg_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
